// File: rtl/alu_req_sequencer.sv
// Round-robin sequencer sharing one registered RV32I ALU between two requesters.
// Decodes funct3/funct7[5], tracks the ALU's one-cycle latency, returns results under valid/ready.
module alu_req_sequencer #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CTRL_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [2:0]        req0_funct3,
  input  logic              req0_funct7_5,
  input  logic              req0_is_imm,
  input  logic [XLEN-1:0]   req0_srca,
  input  logic [XLEN-1:0]   req0_srcb,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [2:0]        req1_funct3,
  input  logic              req1_funct7_5,
  input  logic              req1_is_imm,
  input  logic [XLEN-1:0]   req1_srca,
  input  logic [XLEN-1:0]   req1_srcb,
  output logic [XLEN-1:0]   alu_srca,
  output logic [XLEN-1:0]   alu_srcb,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [XLEN-1:0]   alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [XLEN-1:0]   rsp_data,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StExec, StCapt, StResp} state_e;

  state_e            state_q, state_d;
  logic              last_grant_q;
  logic [XLEN-1:0]   alu_srca_q, alu_srcb_q, rsp_data_q;
  logic [CTRL_W-1:0] alu_ctrl_q;
  logic              rsp_valid_q, rsp_id_q;

  logic              grant0, grant1, transfer;
  logic [2:0]        sel_funct3;
  logic              sel_funct7_5, sel_is_imm;
  logic [XLEN-1:0]   sel_srca, sel_srcb, proc_srcb;
  logic [CTRL_W-1:0] dec_ctrl;

  // When both are valid, the requester that did not win last time gets the ALU.
  always_comb begin
    grant0     = req0_valid & (~req1_valid | last_grant_q);
    grant1     = req1_valid & (~req0_valid | ~last_grant_q);
    req0_ready = ~reset & (state_q == StIdle) & grant0;
    req1_ready = ~reset & (state_q == StIdle) & grant1;
    transfer   = req0_ready | req1_ready;
  end

  always_comb begin
    sel_funct3   = grant1 ? req1_funct3   : req0_funct3;
    sel_funct7_5 = grant1 ? req1_funct7_5 : req0_funct7_5;
    sel_is_imm   = grant1 ? req1_is_imm   : req0_is_imm;
    sel_srca     = grant1 ? req1_srca     : req0_srca;
    sel_srcb     = grant1 ? req1_srcb     : req0_srcb;
  end

  always_comb begin
    dec_ctrl  = '0;
    proc_srcb = sel_srcb;
    unique case (sel_funct3)
      3'b000: dec_ctrl = (sel_funct7_5 & ~sel_is_imm) ? CTRL_W'(4'b1001) : CTRL_W'(4'b0000);
      3'b001: dec_ctrl = CTRL_W'(4'b0001);
      3'b010: dec_ctrl = CTRL_W'(4'b0010);
      3'b011: dec_ctrl = CTRL_W'(4'b0011);
      3'b100: dec_ctrl = CTRL_W'(4'b0100);
      3'b101: dec_ctrl = sel_funct7_5 ? CTRL_W'(4'b1101) : CTRL_W'(4'b0101);
      3'b110: dec_ctrl = CTRL_W'(4'b0110);
      3'b111: dec_ctrl = CTRL_W'(4'b0111);
      default: dec_ctrl = '0;
    endcase
    // Shifts only consume the low five bits of the shift amount.
    if (sel_funct3 == 3'b001 || sel_funct3 == 3'b101) begin
      proc_srcb = {{(XLEN-5){1'b0}}, sel_srcb[4:0]};
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (transfer) state_d = StExec;
      StExec:  state_d = StCapt;
      StCapt:  state_d = StResp;
      StResp:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      alu_srca_q   <= '0;
      alu_srcb_q   <= '0;
      alu_ctrl_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
    end else begin
      state_q <= state_d;
      if (transfer) begin
        alu_srca_q   <= sel_srca;
        alu_srcb_q   <= proc_srcb;
        alu_ctrl_q   <= dec_ctrl;
        rsp_id_q     <= grant1;
        last_grant_q <= grant1;
      end
      // The ALU sampled its operands on the EXEC edge; its result is valid in CAPT.
      if (state_q == StCapt) begin
        rsp_data_q  <= alu_result;
        rsp_valid_q <= 1'b1;
      end else if (state_q == StResp && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign alu_srca  = alu_srca_q;
  assign alu_srcb  = alu_srcb_q;
  assign alu_ctrl  = alu_ctrl_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q != StIdle);

endmodule
